// File: rtl/retreo_io_port.sv
// retreo_io_port
// Core-side I/O port for the ReTReO processor. Host words are buffered in an
// input FIFO whose head drives In_Reg; words the core writes on Out_Reg are
// buffered in an output FIFO drained by the host. A starved core read or a
// blocked core write halts the core through Override_Stall until the access
// can complete.
//
// Optional feature: define RETREO_IO_STATS_EN to add a saturating 16-bit
// stall_count output that counts clock edges spent with Override_Stall high.
//
// Handshake semantics (both host streams): a word transfers on a rising edge
// exactly when valid and ready are both high at that edge. Valid never depends
// on ready. The input side raises host_in_ready whenever the input FIFO has a
// free slot. The output side holds host_out_valid and host_out_data steady
// until the word is taken.
//
// dbg_state exposes the FSM state (0 = RUN, 1 = STALL_IN, 2 = STALL_OUT).

module retreo_io_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    output logic [WIDTH-1:0] In_Reg,
    input  logic             In_Rd,
    input  logic [WIDTH-1:0] Out_Reg,
    input  logic             Out_Wr,
    output logic             Override_Stall,
`ifdef RETREO_IO_STATS_EN
    output logic [15:0]      stall_count,
`endif
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STALL_IN  = 2'd1,
        ST_STALL_OUT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   pend_in;
    logic   pend_in_next;
    logic   stall_q;
    logic   stall_d;

    // ------------------------------------------------------------------
    // Input FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr_ptr;
    logic [AW-1:0]    in_rd_ptr;
    logic [CW-1:0]    in_count;
    logic             in_empty;
    logic             in_full;
    logic             in_push;
    logic             in_pop;

    // ------------------------------------------------------------------
    // Output FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0]    out_wr_ptr;
    logic [AW-1:0]    out_rd_ptr;
    logic [CW-1:0]    out_count;
    logic             out_empty;
    logic             out_full;
    logic             out_push;
    logic             out_pop;
    logic [WIDTH-1:0] out_push_data;

    // Word the core tried to write while the output FIFO was full.
    logic [WIDTH-1:0] skid;
    logic             skid_load;

    // Event decodes shared by the FSM and the datapath.
    logic out_room;   // output FIFO can take a word at this edge
    logic in_starve;  // core read with nothing to read
    logic out_ovf;    // core write with nowhere to put it

    assign in_empty = (in_count == '0);
    assign in_full  = (in_count == FULL_CNT);
    assign out_empty = (out_count == '0);
    assign out_full  = (out_count == FULL_CNT);

    assign host_in_ready  = !in_full;
    assign in_push        = host_in_valid && !in_full;
    assign host_out_valid = !out_empty;
    assign out_pop        = !out_empty && host_out_ready;

    // A full output FIFO still has room when the host pops in the same cycle.
    assign out_room  = !out_full || out_pop;
    // No bypass: a same-cycle host push does not rescue a read of an empty FIFO.
    assign in_starve = In_Rd && in_empty;
    assign out_ovf   = Out_Wr && !out_room;

    // Head words are forced to zero when their FIFO is empty.
    assign In_Reg        = in_empty  ? '0 : in_mem[in_rd_ptr];
    assign host_out_data = out_empty ? '0 : out_mem[out_rd_ptr];

    assign Override_Stall = stall_q;
    assign dbg_state      = state;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register, pending-read flag and registered stall request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            pend_in <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_next;
            pend_in <= pend_in_next;
            stall_q <= stall_d;
        end
    end

    // Next-state logic: enter a stall on a blocked access, leave it as soon
    // as the blocking condition clears at the current edge.
    always_comb begin
        state_next   = state;
        pend_in_next = pend_in;
        case (state)
            ST_RUN: begin
                if (out_ovf) begin
                    // A simultaneous starved read is remembered for later.
                    state_next   = ST_STALL_OUT;
                    pend_in_next = in_starve;
                end else if (in_starve) begin
                    state_next = ST_STALL_IN;
                end
            end
            ST_STALL_IN: begin
                // Release when the FIFO holds a word after this edge; the
                // core re-issues its read on the following cycle.
                if (!in_empty || in_push) begin
                    state_next = ST_RUN;
                end
            end
            ST_STALL_OUT: begin
                if (out_room) begin
                    pend_in_next = 1'b0;
                    if (pend_in && in_empty && !in_push) begin
                        state_next = ST_STALL_IN;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next   = ST_RUN;
                pend_in_next = 1'b0;
            end
        endcase
    end

    // Output decode: FIFO enables, skid capture and the next stall request.
    // Core strobes only act in RUN since the core is halted otherwise.
    always_comb begin
        in_pop        = 1'b0;
        out_push      = 1'b0;
        out_push_data = Out_Reg;
        skid_load     = 1'b0;
        stall_d       = (state_next != ST_RUN);
        case (state)
            ST_RUN: begin
                in_pop    = In_Rd && !in_empty;
                out_push  = Out_Wr && out_room;
                skid_load = out_ovf;
            end
            ST_STALL_OUT: begin
                out_push      = out_room;
                out_push_data = skid;
            end
            default: begin
                in_pop   = 1'b0;
                out_push = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Skid register holds the blocked core write until the FIFO frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid <= '0;
        end else if (skid_load) begin
            skid <= Out_Reg;
        end
    end

    // Input FIFO storage write; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= host_in_data;
        end
    end

    // Input FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_wr_ptr + 1'b1;
            end
            if (in_pop) begin
                in_rd_ptr <= in_rd_ptr + 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
        end
    end

    // Output FIFO storage write; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= out_push_data;
        end
    end

    // Output FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (out_push) begin
                out_wr_ptr <= out_wr_ptr + 1'b1;
            end
            if (out_pop) begin
                out_rd_ptr <= out_rd_ptr + 1'b1;
            end
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

`ifdef RETREO_IO_STATS_EN
    // Saturating count of edges at which the core was being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_q && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_retreo_io_port.sv
// tb_retreo_io_port
// Directed bench for retreo_io_port: reset values, input FIFO fill/drain,
// starved read stall, output overflow stall with in-order drain, combined
// stall, mid-stall asynchronous reset, and (with RETREO_IO_STATS_EN) the
// stall counter including saturation.

module tb_retreo_io_port;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    // Clock / reset
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT signals
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [WIDTH-1:0] In_Reg;
    logic             In_Rd;
    logic [WIDTH-1:0] Out_Reg;
    logic             Out_Wr;
    logic             Override_Stall;
    logic [1:0]       dbg_state;
`ifdef RETREO_IO_STATS_EN
    logic [15:0]      stall_count;
`endif

    retreo_io_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .In_Reg         (In_Reg),
        .In_Rd          (In_Rd),
        .Out_Reg        (Out_Reg),
        .Out_Wr         (Out_Wr),
        .Override_Stall (Override_Stall),
`ifdef RETREO_IO_STATS_EN
        .stall_count    (stall_count),
`endif
        .dbg_state      (dbg_state)
    );

    // Scoreboard state
    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs change and outputs are sampled 1 unit after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        In_Rd          = 1'b0;
        Out_Reg        = '0;
        Out_Wr         = 1'b0;

        // ---------------- reset values ----------------
        #11;
        chk("rst_stall", Override_Stall, 0);
        chk("rst_in_reg", In_Reg, 0);
        chk("rst_out_data", host_out_data, 0);
        chk("rst_out_valid", host_out_valid, 0);
        chk("rst_in_ready", host_in_ready, 1);
        chk("rst_state", dbg_state, 0);
`ifdef RETREO_IO_STATS_EN
        chk("rst_stall_count", stall_count, 0);
`endif
        #1 rst_n = 1'b1;
        step();

        // ---------------- single push then read ----------------
        host_in_data  = 16'h0004;
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        chk("t1_in_reg_push", In_Reg, 16'h0004);
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("t1_in_reg_pop", In_Reg, 0);
        chk("t1_in_ready", host_in_ready, 1);
        chk("t1_stall", Override_Stall, 0);

        // ---------------- fill input FIFO ----------------
        host_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            host_in_data = 16'(i);
            step();
        end
        chk("t2_full_ready", host_in_ready, 0);
        host_in_data = 16'h0005;
        step();
        chk("t2_no_push_head", In_Reg, 16'h0001);
        chk("t2_no_push_ready", host_in_ready, 0);
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("t2_after_rd_head", In_Reg, 16'h0002);
        chk("t2_after_rd_ready", host_in_ready, 1);
        step();
        host_in_valid = 1'b0;
        chk("t2_refull_ready", host_in_ready, 0);
        for (int k = 2; k <= 5; k++) begin
            chk("t2_drain_word", In_Reg, 32'(k));
            In_Rd = 1'b1;
            step();
        end
        In_Rd = 1'b0;
        chk("t2_drained", In_Reg, 0);
        chk("t2_stall", Override_Stall, 0);

        // ---------------- starved read ----------------
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("t3_stall_enter", Override_Stall, 1);
        chk("t3_state_in", dbg_state, 1);
        step();
        chk("t3_stall_hold1", Override_Stall, 1);
        step();
        chk("t3_stall_hold2", Override_Stall, 1);
        host_in_data  = 16'h00AA;
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        chk("t3_stall_release", Override_Stall, 0);
        chk("t3_in_reg", In_Reg, 16'h00AA);
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("t3_retry_pop", In_Reg, 0);
        chk("t3_retry_stall", Override_Stall, 0);

        // ---------------- output overflow ----------------
        for (int i = 0; i < 4; i++) begin
            Out_Reg = 16'h0010 + 16'(i);
            Out_Wr  = 1'b1;
            exp_q.push_back(Out_Reg);
            step();
        end
        Out_Wr = 1'b0;
        chk("t4_out_valid", host_out_valid, 1);
        chk("t4_out_head", host_out_data, 16'h0010);
        chk("t4_no_stall_full", Override_Stall, 0);
        Out_Reg = 16'h0014;
        Out_Wr  = 1'b1;
        exp_q.push_back(Out_Reg);
        step();
        Out_Wr = 1'b0;
        chk("t4_stall_enter", Override_Stall, 1);
        chk("t4_state_out", dbg_state, 2);
        step();
        chk("t4_stall_hold", Override_Stall, 1);
        host_out_ready = 1'b1;
        chk("t4_first_word", host_out_data, 32'(exp_q.pop_front()));
        step();
        chk("t4_stall_release", Override_Stall, 0);
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            chk("t4_drain_valid", host_out_valid, 1);
            chk("t4_drain_word", host_out_data, 32'(exp_q.pop_front()));
            step();
        end
        host_out_ready = 1'b0;
        chk("t4_drain_left", 32'(exp_q.size()), 0);
        chk("t4_drain_empty", host_out_valid, 0);

        // ---------------- combined stall ----------------
        for (int i = 0; i < 4; i++) begin
            Out_Reg = 16'h0020 + 16'(i);
            Out_Wr  = 1'b1;
            step();
        end
        Out_Reg = 16'h0024;
        In_Rd   = 1'b1;
        step();
        Out_Wr = 1'b0;
        In_Rd  = 1'b0;
        chk("t5_stall_out", Override_Stall, 1);
        chk("t5_state_out", dbg_state, 2);
        step();
        chk("t5_stall_out_hold", Override_Stall, 1);
        host_out_ready = 1'b1;
        chk("t5_pop_word", host_out_data, 16'h0020);
        step();
        host_out_ready = 1'b0;
        chk("t5_stall_in", Override_Stall, 1);
        chk("t5_state_in", dbg_state, 1);
        step();
        chk("t5_stall_in_hold", Override_Stall, 1);
        host_in_data  = 16'h00BB;
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        chk("t5_release", Override_Stall, 0);
        chk("t5_state_run", dbg_state, 0);
        chk("t5_in_reg", In_Reg, 16'h00BB);
        host_out_ready = 1'b1;
        for (int k = 16'h21; k <= 16'h24; k++) begin
            chk("t5_drain_word", host_out_data, 32'(k));
            step();
        end
        host_out_ready = 1'b0;
        chk("t5_out_empty", host_out_valid, 0);
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("t5_in_empty", In_Reg, 0);

`ifdef RETREO_IO_STATS_EN
        // ---------------- stall counter ----------------
        rst_n = 1'b0;
        #1;
        chk("s_rst_count", stall_count, 0);
        rst_n = 1'b1;
        step();
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("s_stall_on", Override_Stall, 1);
        step();
        step();
        host_in_data  = 16'h0001;
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        chk("s_stall_off", Override_Stall, 0);
        chk("s_count3", stall_count, 3);
        In_Rd = 1'b1;
        step();
        step();
        In_Rd = 1'b0;
        chk("s_long_stall_on", Override_Stall, 1);
        repeat (70000) step();
        chk("s_count_sat", stall_count, 16'hFFFF);
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        In_Rd = 1'b1;
        step();
        In_Rd = 1'b0;
        chk("s_long_release", Override_Stall, 0);
`endif

        // ---------------- reset mid-stall ----------------
        for (int i = 0; i < 4; i++) begin
            Out_Reg = 16'h0030 + 16'(i);
            Out_Wr  = 1'b1;
            step();
        end
        Out_Reg = 16'h0034;
        step();
        Out_Wr        = 1'b0;
        host_in_data  = 16'h0055;
        host_in_valid = 1'b1;
        step();
        host_in_valid = 1'b0;
        chk("r_pre_stall", Override_Stall, 1);
        chk("r_pre_in_reg", In_Reg, 16'h0055);
        rst_n = 1'b0;
        #1;
        chk("r_async_stall", Override_Stall, 0);
        chk("r_async_in_reg", In_Reg, 0);
        chk("r_async_out_data", host_out_data, 0);
        chk("r_async_out_valid", host_out_valid, 0);
        chk("r_async_in_ready", host_in_ready, 1);
        chk("r_async_state", dbg_state, 0);
`ifdef RETREO_IO_STATS_EN
        chk("r_async_count", stall_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        host_out_ready = 1'b1;
        step();
        step();
        chk("r_skid_gone", host_out_valid, 0);
        chk("r_in_gone", In_Reg, 0);
        chk("r_post_stall", Override_Stall, 0);
        host_out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retreo_io_port.md
# retreo_io_port

Core-side I/O port for the ReTReO processor, sitting between the core's `In_Reg`/`Out_Reg`/`Override_Stall` pins and a host-side valid/ready stream interface. Host words are buffered in an input FIFO whose head drives `In_Reg`. Words the core produces on `Out_Reg` are buffered in an output FIFO drained by the host. When the core reads from an empty input buffer or writes to a full output buffer, the block holds the core with `Override_Stall` until the access can complete.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `WIDTH`, 16: data width; matches the core's `In_Reg`/`Out_Reg`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_in_data` in WIDTH: host word to the core.
- `host_in_valid` in 1: host word present.
- `host_in_ready` out 1: input FIFO can accept a word.
- `host_out_data` out WIDTH: head of the output FIFO.
- `host_out_valid` out 1: output FIFO not empty.
- `host_out_ready` in 1: host consumes the head word.
- `In_Reg` out WIDTH: head of the input FIFO, presented to the core.
- `In_Rd` in 1: one-cycle strobe; the core consumes `In_Reg` this cycle.
- `Out_Reg` in WIDTH: core output word.
- `Out_Wr` in 1: one-cycle strobe; the core writes `Out_Reg` this cycle.
- `Override_Stall` out 1: registered halt request to the core.

## Operation
**Input FIFO**
- Push on `host_in_valid & host_in_ready`.
- Pop on `In_Rd` in RUN when not empty.
- `host_in_ready = !in_full`. No bypass: a push and a pop on an empty FIFO in the same cycle is a starved read.
- `In_Reg` = head word, or 0 when empty.

**Output FIFO**
- Push from `Out_Wr` in RUN, or from the skid register in STALL_OUT.
- Pop on `host_out_valid & host_out_ready`.
- A push is allowed when full if a pop happens in the same cycle.
- `host_out_data` = head word, or 0 when empty.

**Occupancy**
- Counters are `$clog2(DEPTH)+1` bits; read/write pointers wrap modulo DEPTH.

**FSM (RUN, STALL_IN, STALL_OUT)**
- RUN, `In_Rd` with input FIFO empty: the read is dropped and the FSM goes to STALL_IN.
- RUN, `Out_Wr` while full and no host pop: `Out_Reg` is latched into the skid register and the FSM goes to STALL_OUT.
- Both events in the same cycle: go to STALL_OUT and set `pend_in`.
- STALL_IN: exit to RUN on the first edge at which the input FIFO is not empty. The core re-issues `In_Rd`.
- STALL_OUT: on the first edge at which the output FIFO is not full, or is popped in that cycle, push the skid word. Next state is STALL_IN if `pend_in` is set and the input FIFO is empty, else RUN. Clear `pend_in`.
- `Override_Stall = (state != RUN)`, taken from a register.
- `In_Rd` and `Out_Wr` are ignored outside RUN because the core is halted.

**Reset (`rst_n` low)**
- Both FIFOs empty, state RUN, `pend_in` = 0.
- Outputs: `Override_Stall` = 0, `In_Reg` = 0, `host_out_data` = 0, `host_out_valid` = 0, `host_in_ready` = 1.
- Reset mid-stall discards the skid word and all buffered data.

## Timing
- Host push at edge N into an empty input FIFO: `In_Reg` shows the word after edge N.
- Core write at edge N into an empty output FIFO: `host_out_valid` = 1 after edge N.
- Stall entry: strobe sampled at edge N, `Override_Stall` = 1 after edge N.
- STALL_IN release: host push at edge M, `Override_Stall` = 0 after edge M, earliest retry at edge M+1.
- STALL_OUT release: host pop at edge M, skid word written at edge M, stall drops after edge M.
- Full throughput: one push and one pop per FIFO per cycle.

## Configuration
- `RETREO_IO_STATS_EN` defined:
  - Adds output `stall_count` (16 bits).
  - Increments on every edge where `Override_Stall` = 1.
  - Saturates at 0xFFFF.
  - Reset value 0.
- `RETREO_IO_STATS_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then a host push of 0x0004 at edge 1 → `In_Reg` = 0x0004 after edge 1. `In_Rd` at edge 2 → `In_Reg` = 0, `host_in_ready` = 1.
- Push 0x0001..0x0004 with `host_in_valid` held high → `host_in_ready` = 0 after the 4th push. A 5th word is not accepted until one `In_Rd`.
- `In_Rd` on an empty FIFO at edge N → `Override_Stall` = 1 for edges N+1..M while empty. Host push 0x00AA at edge M → stall = 0 after M, and `In_Reg` = 0x00AA.
- Fill the output FIFO with 0x0010..0x0013 while `host_out_ready` = 0, then `Out_Wr` with 0x0014 → stall asserted. Raise `host_out_ready` → host drains 0x0010..0x0014 in order with no loss or duplication.
- Output FIFO full and input FIFO empty, with `Out_Wr` and `In_Rd` in the same cycle → STALL_OUT, then STALL_IN, then RUN after a host pop and a host push. `Override_Stall` stays 1 throughout with no glitch.
- With `RETREO_IO_STATS_EN` defined: 3-cycle stall → `stall_count` = 3. Force 70000 stall cycles → `stall_count` = 0xFFFF. Assert `rst_n` low mid-stall → all outputs return to reset values asynchronously.
